// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants and types for the push-button conditioner
package btn_pkg;

    localparam int BTN_COUNT = 5;

    localparam int BTN_C = 0;
    localparam int BTN_L = 1;
    localparam int BTN_U = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

    typedef enum logic [1:0] {
        RP_IDLE   = 2'd0,
        RP_HOLD   = 2'd1,
        RP_REPEAT = 2'd2
    } rp_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button pins in, conditioned levels and pulses out
interface button_conditioner_if
    import btn_pkg::*;
#(
    parameter int N_BTN = BTN_COUNT
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: 2-flop synchroniser, debouncer and auto-repeat FSM
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100,
    parameter int REPEAT_DELAY    = 2000,
    parameter int REPEAT_RATE     = 500,
    parameter int REPEAT_EN       = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

    logic            s1;
    logic            s2;
    logic            stable;
    logic [DB_W-1:0] db_cnt;
    logic            db_done;
    logic            rise;
    logic            fall;

    // rise/fall are evaluated in the same cycle stable flips, so the pulses line up with btn_level
    assign db_done = (s2 != stable) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign rise    = db_done & s2;
    assign fall    = db_done & ~s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            db_cnt <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
            if (s2 == stable) begin
                db_cnt <= '0;
            end else if (db_done) begin
                stable <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    rp_state_t       state_q;
    rp_state_t       state_d;
    logic [RP_W-1:0] rp_cnt_q;
    logic [RP_W-1:0] rp_cnt_d;
    logic            press_d;
    logic            release_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RP_IDLE;
            rp_cnt_q    <= '0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state_q     <= state_d;
            rp_cnt_q    <= rp_cnt_d;
            btn_press   <= press_d;
            btn_release <= release_d;
        end
    end

    // A fall overrides any repeat that would land in the same cycle
    always_comb begin
        state_d   = state_q;
        rp_cnt_d  = rp_cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (fall) begin
            release_d = 1'b1;
            state_d   = RP_IDLE;
            rp_cnt_d  = '0;
        end else begin
            case (state_q)
                RP_IDLE: begin
                    if (rise) begin
                        press_d  = 1'b1;
                        state_d  = RP_HOLD;
                        rp_cnt_d = '0;
                    end
                end
                RP_HOLD: begin
                    // with repeat disabled the counter parks at the delay threshold
                    if (rp_cnt_q == RP_W'(REPEAT_DELAY - 1)) begin
                        if (REPEAT_EN != 0) begin
                            press_d  = 1'b1;
                            state_d  = RP_REPEAT;
                            rp_cnt_d = '0;
                        end
                    end else begin
                        rp_cnt_d = rp_cnt_q + 1'b1;
                    end
                end
                RP_REPEAT: begin
                    if (rp_cnt_q == RP_W'(REPEAT_RATE - 1)) begin
                        press_d  = 1'b1;
                        rp_cnt_d = '0;
                    end else begin
                        rp_cnt_d = rp_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = RP_IDLE;
                    rp_cnt_d = '0;
                end
            endcase
        end
    end

    assign btn_level = stable;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - array of independent button channels behind the board pins
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = BTN_COUNT,
    parameter int DEBOUNCE_CYCLES = 100,
    parameter int REPEAT_DELAY    = 2000,
    parameter int REPEAT_RATE     = 500,
    parameter int REPEAT_EN       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);
    logic [N_BTN-1:0] level_w;
    logic [N_BTN-1:0] press_w;
    logic [N_BTN-1:0] release_w;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .REPEAT_EN       (REPEAT_EN)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .btn_raw     (bus.btn_in[i]),
            .btn_level   (level_w[i]),
            .btn_press   (press_w[i]),
            .btn_release (release_w[i])
        );
    end

    assign bus.btn_level   = level_w;
    assign bus.btn_press   = press_w;
    assign bus.btn_release = release_w;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int LAT = 102;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    button_conditioner_if #(.N_BTN(BTN_COUNT)) bif ();

    button_conditioner #(
        .N_BTN           (BTN_COUNT),
        .DEBOUNCE_CYCLES (100),
        .REPEAT_DELAY    (2000),
        .REPEAT_RATE     (500),
        .REPEAT_EN       (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        int         cyc;
        logic [4:0] press;
        logic [4:0] rel;
        logic [4:0] lvl;
    } ev_t;

    ev_t sb[$];
    int  cyc     = 0;
    int  vectors = 0;
    int  fails   = 0;
    bit  mon_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && ((bif.btn_press | bif.btn_release) != 5'b0)) begin
            vectors++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: cyc=%0d press=%b release=%b level=%b, none expected",
                         cyc, bif.btn_press, bif.btn_release, bif.btn_level);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || e.press !== bif.btn_press || e.rel !== bif.btn_release ||
                    e.lvl !== bif.btn_level) begin
                    fails++;
                    $display("FAIL pulse_event: got cyc=%0d press=%b release=%b level=%b, expected cyc=%0d press=%b release=%b level=%b",
                             cyc, bif.btn_press, bif.btn_release, bif.btn_level,
                             e.cyc, e.press, e.rel, e.lvl);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int c, input logic [4:0] p, input logic [4:0] r, input logic [4:0] l);
        ev_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        e.lvl   = l;
        sb.push_back(e);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string name);
        cmp(name, {17'b0, bif.btn_level, bif.btn_press, bif.btn_release}, 32'h0);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        vectors++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d expected events never seen, expected 0 outstanding", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #(10 * 60000);
        fails++;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $fatal(1);
    end

    initial begin
        int t0;
        bif.btn_in = 5'b0;
        rst        = 1'b1;
        tick(5);
        check_quiet("reset_state");
        rst    = 1'b0;
        mon_en = 1'b1;

        // idle
        for (int i = 0; i < 10; i++) begin
            tick(100);
            check_quiet("idle");
        end

        // clean press on D
        bif.btn_in[BTN_D] = 1'b1;
        expect_ev(cyc + LAT, 5'b10000, 5'b00000, 5'b10000);
        tick(LAT - 1);
        cmp("d_level_before", {31'b0, bif.btn_level[BTN_D]}, 32'd0);
        tick(1);
        cmp("d_level_after", {31'b0, bif.btn_level[BTN_D]}, 32'd1);
        tick(400 - LAT);
        bif.btn_in[BTN_D] = 1'b0;
        expect_ev(cyc + LAT, 5'b00000, 5'b10000, 5'b00000);
        drain("clean_press", 300);

        // bounce on R, final rising edge then held
        for (int i = 0; i < 10; i++) begin
            bif.btn_in[BTN_R] = (i % 2 == 0);
            tick(30);
        end
        bif.btn_in[BTN_R] = 1'b1;
        expect_ev(cyc + LAT, 5'b01000, 5'b00000, 5'b01000);
        tick(300);
        bif.btn_in[BTN_R] = 1'b0;
        expect_ev(cyc + LAT, 5'b00000, 5'b01000, 5'b00000);
        drain("bounce", 300);

        // 99-cycle glitch on L
        bif.btn_in[BTN_L] = 1'b1;
        tick(99);
        bif.btn_in[BTN_L] = 1'b0;
        tick(300);
        check_quiet("glitch_99");

        // auto-repeat on U
        bif.btn_in[BTN_U] = 1'b1;
        t0 = cyc + LAT;
        expect_ev(t0, 5'b00100, 5'b00000, 5'b00100);
        for (int k = 0; k < 4; k++)
            expect_ev(t0 + 2000 + 500 * k, 5'b00100, 5'b00000, 5'b00100);
        tick(4000);
        bif.btn_in[BTN_U] = 1'b0;
        expect_ev(t0 + 4000, 5'b00000, 5'b00100, 5'b00000);
        drain("auto_repeat", 300);

        // L and R together
        bif.btn_in = 5'b01010;
        expect_ev(cyc + LAT, 5'b01010, 5'b00000, 5'b01010);
        tick(400);
        bif.btn_in = 5'b00000;
        expect_ev(cyc + LAT, 5'b00000, 5'b01010, 5'b00000);
        drain("simultaneous", 300);

        // reset while U is repeating
        bif.btn_in[BTN_U] = 1'b1;
        t0 = cyc + LAT;
        expect_ev(t0, 5'b00100, 5'b00000, 5'b00100);
        expect_ev(t0 + 2000, 5'b00100, 5'b00000, 5'b00100);
        tick(LAT + 2100);
        cmp("hold_level", {31'b0, bif.btn_level[BTN_U]}, 32'd1);
        rst = 1'b1;
        tick(1);
        check_quiet("reset_mid_hold");
        rst = 1'b0;
        expect_ev(cyc + LAT, 5'b00100, 5'b00000, 5'b00100);
        tick(LAT + 100);
        bif.btn_in[BTN_U] = 1'b0;
        expect_ev(cyc + LAT, 5'b00000, 5'b00100, 5'b00000);
        drain("reset_mid_hold_events", 300);

        tick(10);
        cmp("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
